pc_controller: RTL
==================

Name: pc_controller

Overview:
- Sequencing controller for the fetch-stage PC (pc register plus next-PC mux) in the pipelined RV32I core.
- Decides every cycle whether the PC holds, advances, restarts or redirects, and drives the pipeline stall/flush lines.
- Handles start/restart via trigger, load-use hazards, instruction-memory wait, taken branches/jumps, and halt.
- Keeps saturating cycle and stall performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register-file index width
CNT_WIDTH, 32, performance counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset)
trigger  input  1  start/restart request, level; acted on at rising edge
imem_ready  input  1  instruction memory has the word for the current PC
rs1_d  input  REG_ADDR_WIDTH  rs1 of instruction in Decode
rs2_d  input  REG_ADDR_WIDTH  rs2 of instruction in Decode
rd_e  input  REG_ADDR_WIDTH  rd of instruction in Execute
memread_e  input  1  instruction in Execute is a load
pcsrc_e  input  1  branch taken / jump resolved in Execute
halt_d  input  1  instruction in Decode is the halt (ecall) encoding
en_n  output  1  PC register hold, active-low enable (1 = hold)
pcsrc  output  1  next-PC mux select (1 = branch/jump target)
pc_rst  output  1  next-PC mux forces reset vector
stall_f  output  1  freeze Fetch
stall_d  output  1  freeze F/D register
flush_d  output  1  bubble F/D register
flush_e  output  1  bubble D/E register
imem_req  output  1  fetch request to instruction memory
running  output  1  state is RUN or WAIT
cycle_cnt  output  CNT_WIDTH  cycles spent in RUN/WAIT
stall_cnt  output  CNT_WIDTH  RUN/WAIT cycles with stall_f = 1

Behaviour:
- States: IDLE, RUN, WAIT, HALT. trig_q is a register of trigger. trig_rise = trigger & ~trig_q.
- Reset (rst = 0, async): state IDLE, trig_q 0, counters 0.
- Outputs in IDLE/HALT: en_n 1, pc_rst 1, pcsrc 0, stall_f 0, stall_d 0, flush_d 1, flush_e 1, imem_req 0, running 0.
- IDLE/HALT + trig_rise: same cycle en_n 0 and pc_rst 1, so the PC loads the reset vector; next state RUN. trigger held high causes no further restarts.
- RUN: imem_req 1, pc_rst 0, running 1. Priority within a cycle:
  1. pcsrc_e: pcsrc 1, en_n 0, flush_d 1, flush_e 1, no stall. Overrides load-use, imem wait and halt_d (halt_d is wrong-path). Stay RUN.
  2. halt_d: en_n 1, flush_d 1; next state HALT. The halt instruction proceeds down the pipe; no flush_e.
  3. Load-use: memread_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d). Drive stall_f 1, stall_d 1, flush_e 1, en_n 1. Exactly one bubble per occurrence.
  4. ~imem_ready: stall_f 1, stall_d 1, flush_e 1, en_n 1; next state WAIT.
  5. Otherwise: en_n 0, pcsrc 0, all stall/flush 0.
- WAIT: imem_req 1, stall_f 1, stall_d 1, flush_e 1, en_n 1.
  - imem_ready: outputs as RUN-normal this cycle, next state RUN.
  - pcsrc_e in WAIT: redirect as RUN rule 1; next state RUN. The new fetch re-enters WAIT if memory is not ready.
  - halt_d is ignored in WAIT; the F/D stage is frozen.
- trig_rise during RUN/WAIT: ignored.
- Async reset mid-operation: immediate return to IDLE, counters 0.
- Counters:
  - cycle_cnt increments every RUN/WAIT cycle.
  - stall_cnt increments when running & stall_f.
  - Both saturate at all-ones and never wrap.
  - Both clear only on reset; a restart via trigger does not clear them.
- stall_f/stall_d and en_n are mutually consistent: en_n = 1 whenever stall_f = 1.
- rd_e = 0 never causes a stall.

Decomposition:
- Package pc_ctrl_pkg:
  - state enum typedef (IDLE, RUN, WAIT, HALT), 2 bits
  - HALT_ENCODING constant
  - default widths
- Sub-module hazard_detect: purely combinational load-use compare producing lu_stall. It is reused by the forwarding unit.
- Counters are inline in pc_controller.

Test Plan:
- Reset then trigger 0→1 at cycle 3 → cycle 3: en_n 0, pc_rst 1. Cycle 4: running 1, en_n 0, pc_rst 0. Holding trigger high for 10 cycles → no further pc_rst.
- RUN; memread_e 1, rd_e 5, rs2_d 5 for one cycle → that cycle: stall_f 1, stall_d 1, flush_e 1, en_n 1. Next cycle normal. stall_cnt +1. Same test with rd_e 0 → no stall.
- RUN; pcsrc_e 1 together with a load-use match and imem_ready 0 → pcsrc 1, en_n 0, flush_d 1, flush_e 1, stall_f 0; state remains RUN.
- RUN; imem_ready 0 for 3 cycles then 1 → WAIT for 3 cycles with en_n 1, stall_f 1. Release cycle en_n 0. cycle_cnt +4, stall_cnt +3.
- RUN; halt_d 1 → en_n 1, flush_d 1. Next cycle HALT: running 0, pc_rst 1, counters frozen. Trigger rising edge → PC reloads reset vector, back to RUN.
- Force cycle_cnt to 2^CNT_WIDTH−2 (use CNT_WIDTH 4: start at 14) and run 5 cycles → holds at 15. Drop rst low mid-WAIT → IDLE same cycle, counters 0, en_n 1.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC sequencing controller:
// state encoding, default widths and the halt instruction encoding.
package pc_ctrl_pkg;

  // Controller state; 2-bit encoding kept stable for legacy users.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  // Default widths for the register index and the performance counters.
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;
  localparam int DEFAULT_CNT_WIDTH      = 32;

  // The ecall word that Decode recognises as halt.
  localparam logic [31:0] HALT_ENCODING = 32'h0000_0073;

endpackage : pc_ctrl_pkg

// File: rtl/pc_controller_if.sv
// Control bundle between the PC sequencing controller (master) and the
// pipeline/fetch datapath it steers (slave).
interface pc_controller_if #(
  parameter int REG_ADDR_WIDTH = pc_ctrl_pkg::DEFAULT_REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = pc_ctrl_pkg::DEFAULT_CNT_WIDTH
);
  // Pipeline status towards the controller
  logic                      trigger;
  logic                      imem_ready;
  logic [REG_ADDR_WIDTH-1:0] rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_e;
  logic                      memread_e;
  logic                      pcsrc_e;
  logic                      halt_d;

  // Controller decisions towards the pipeline
  logic                      en_n;
  logic                      pcsrc;
  logic                      pc_rst;
  logic                      stall_f;
  logic                      stall_d;
  logic                      flush_d;
  logic                      flush_e;
  logic                      imem_req;
  logic                      running;
  logic [CNT_WIDTH-1:0]      cycle_cnt;
  logic [CNT_WIDTH-1:0]      stall_cnt;

  modport master (
    input  trigger, imem_ready, rs1_d, rs2_d, rd_e, memread_e, pcsrc_e, halt_d,
    output en_n, pcsrc, pc_rst, stall_f, stall_d, flush_d, flush_e, imem_req,
           running, cycle_cnt, stall_cnt
  );

  modport slave (
    output trigger, imem_ready, rs1_d, rs2_d, rd_e, memread_e, pcsrc_e, halt_d,
    input  en_n, pcsrc, pc_rst, stall_f, stall_d, flush_d, flush_e, imem_req,
           running, cycle_cnt, stall_cnt
  );

endinterface : pc_controller_if

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the instruction in Execute is a load whose
// destination feeds a source of the instruction in Decode. x0 never hazards.
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = pc_ctrl_pkg::DEFAULT_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      memread_e,
  output logic                      lu_stall
);

  // Pure compare; shared with the forwarding unit.
  assign lu_stall = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

endmodule : hazard_detect

// File: rtl/pc_controller.sv
// Fetch-stage PC sequencing controller: chooses hold / advance / restart /
// redirect each cycle, drives pipeline stall and flush lines, and keeps
// saturating cycle and stall counters.
module pc_controller
  import pc_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  pc_controller_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_HALT = 2'(ST_HALT);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 trig_q;
  logic                 trig_rise;
  logic                 lu_stall;
  logic                 running;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] stall_q;

  logic en_n;
  logic pcsrc;
  logic pc_rst;
  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;
  logic imem_req;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard (
    .rs1_d     (bus.rs1_d),
    .rs2_d     (bus.rs2_d),
    .rd_e      (bus.rd_e),
    .memread_e (bus.memread_e),
    .lu_stall  (lu_stall)
  );

  assign trig_rise = bus.trigger && !trig_q;
  assign running   = (state_q == S_RUN) || (state_q == S_WAIT);

  // Next-state and control-line decode, in priority order per state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    en_n     = 1'b1;
    pcsrc    = 1'b0;
    pc_rst   = 1'b1;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b1;
    flush_e  = 1'b1;
    imem_req = 1'b0;

    case (state_q)
      S_RUN: begin
        imem_req = 1'b1;
        pc_rst   = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        en_n     = 1'b0;
        if (bus.pcsrc_e) begin
          // Redirect wins; anything in Decode is wrong-path.
          pcsrc   = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (bus.halt_d) begin
          // Halt flows on down the pipe; stop fetching behind it.
          en_n    = 1'b1;
          flush_d = 1'b1;
          state_d = S_HALT;
        end else if (lu_stall) begin
          en_n    = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (!bus.imem_ready) begin
          en_n    = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        imem_req = 1'b1;
        pc_rst   = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        en_n     = 1'b0;
        if (bus.pcsrc_e) begin
          pcsrc   = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          state_d = S_RUN;
        end else if (bus.imem_ready) begin
          state_d = S_RUN;
        end else begin
          // F/D is frozen here, so halt_d is not looked at.
          en_n    = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      default: begin
        // IDLE and HALT: a trigger edge loads the reset vector this cycle.
        if (trig_rise) begin
          en_n    = 1'b0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // State and trigger-edge registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      trig_q  <= bus.trigger;
    end
  end

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (running) begin
      if (cycle_q != CNT_MAX) cycle_q <= cycle_q + CNT_ONE;
      if (stall_f && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_ONE;
    end
  end

  assign bus.en_n      = en_n;
  assign bus.pcsrc     = pcsrc;
  assign bus.pc_rst    = pc_rst;
  assign bus.stall_f   = stall_f;
  assign bus.stall_d   = stall_d;
  assign bus.flush_d   = flush_d;
  assign bus.flush_e   = flush_e;
  assign bus.imem_req  = imem_req;
  assign bus.running   = running;
  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_q;

endmodule : pc_controller
